// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: binary-to-BCD (double dabble) converter with a multiplexed seven-segment scanner.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int BIN_WIDTH   = 27,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            cathode,
    output logic [NUM_DIGITS-1:0] anode
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] max_val();
        logic [63:0] m;
        m = 64'd1;
        for (int i = 0; i < NUM_DIGITS; i++) m = m * 64'd10;
        return m - 64'd1;
    endfunction

    localparam logic [63:0] MAX = max_val();

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [DW-1:0]         bcd_q, bcd_d, adj, disp_q, disp_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic                  ovp_q, ovp_d, ovf_q, ovf_d;
    logic [CW-1:0]         ref_q, ref_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  run_q, run_d;
    logic [6:0]            cat_q, cat_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, blank;
    logic [3:0]            nib;
    logic                  bsel, tc;

    // State register for converter, display and scanner
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovp_q   <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
            cat_q   <= 7'h7F;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovp_q   <= ovp_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            cat_q   <= cat_d;
            an_q    <= an_d;
        end
    end

    // Double-dabble FSM; the display only changes in DONE so partial results never show
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovp_d   = ovp_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        adj     = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        case (state_q)
            IDLE: if (load) begin
                bin_d   = value;
                bcd_d   = '0;
                cnt_d   = '0;
                ovp_d   = 64'(value) > MAX;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + SW'(1);
                state_d        = cnt_q == SW'(BIN_WIDTH - 1) ? DONE : SHIFT;
            end
            DONE: begin
                disp_d  = bcd_q;
                ovf_d   = ovp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Leading-zero mask: a digit is blank when it and every higher digit are zero
    always_comb begin
        blank = '0;
`ifdef SEVEN_SEG_BLANK_EN
        begin
            logic zero;
            zero = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                zero     = zero & (disp_q[4*i +: 4] == 4'd0);
                blank[i] = zero && (i != 0) && !ovf_q;
            end
        end
`endif
    end

    // Refresh counter and digit scanner; outputs load only when the digit index moves
    always_comb begin
        tc    = ref_q == CW'(REFRESH_DIV - 1);
        ref_d = tc ? '0 : ref_q + CW'(1);
        idx_d = !tc ? idx_q : (!run_q || idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        run_d = run_q | tc;
        nib   = '0;
        bsel  = 1'b0;
        an_d  = an_q;
        cat_d = cat_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                nib  = disp_q[4*i +: 4];
                bsel = blank[i];
            end
        end
        if (tc) begin
            for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = !(IW'(i) == idx_d && !blank[i]);
            cat_d = ovf_q ? 7'h3F : bsel ? 7'h7F : seg(nib);
        end
    end

    assign busy     = state_q != IDLE;
    assign overflow = ovf_q;
    assign cathode  = cat_q;
    assign anode    = an_q;
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Parametrised multi-digit seven-segment display controller: converts a binary value to BCD with a sequential double-dabble engine, then time-multiplexes NUM_DIGITS digits onto shared cathodes.
- Sits between datapath counters/results and the board's anode/cathode pins.
- Successor to the fixed 8-digit scanner: adds configurable digit count and refresh rate, a load/busy handshake, atomic display update, overflow indication and reset.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8); anode width.
- BIN_WIDTH, 27, width of the binary input value.
- REFRESH_DIV, 100000, system clocks per digit slot (1 ms at 100 MHz); must be >= 2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  BIN_WIDTH  binary number to display; sampled only on an accepted load.
- load  in  1  request conversion of value; accepted only when busy=0.
- busy  out  1  high while a conversion is in progress.
- overflow  out  1  high when the displayed value exceeds 10^NUM_DIGITS-1.
- cathode  out  7  segments {g,f,e,d,c,b,a}; active-low.
- anode  out  NUM_DIGITS  digit enables; active-low, one-hot-zero.

Behaviour:
- Reset (async, reset_n=0): busy=0, overflow=0, cathode=7'h7F, anode=all ones, display BCD register=0, digit index=0, refresh counter=0, converter FSM=IDLE. Asserting reset mid-conversion aborts the conversion; no partial result is committed.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: when load=1, capture value into the shift register, clear the BCD accumulator (NUM_DIGITS*4 bits) and shift count, then go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After BIN_WIDTH shifts go to DONE.
  - DONE: commit the accumulator to the display register and latch overflow, then go to IDLE.
- busy = (state != IDLE). For a load accepted at edge t, busy is high from edge t through edge t+BIN_WIDTH+1.
- The new digits and overflow are visible from edge t+BIN_WIDTH+1. The display register never shows a partial conversion.
- load while busy=1 (including in DONE) is ignored, not queued. value changes while busy have no effect.
- Overflow: at elaboration, MAX = 10^NUM_DIGITS-1. overflow=1 if the captured value > MAX; otherwise 0. If 2^BIN_WIDTH-1 <= MAX, overflow is constant 0.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously and wraps.
  - On the terminal count, the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
  - Digit 0 is the least-significant digit (rightmost).
- Outputs are registered on the cycle the digit index changes:
  - anode[i]=0 only for i == new index.
  - cathode = decode(display nibble at new index).
  - Until the first terminal count after reset, anode stays all ones.
- Decoder, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); any other nibble = 7F (blank).
- When overflow=1, every digit shows a dash, cathode=3F, regardless of BCD contents.
- Scanning never stalls for conversions or loads.

Optional Feature:
- Macro: SEVEN_SEG_BLANK_EN.
- Defined: leading-zero blanking. A digit whose nibble and all higher-significance nibbles are 0 shows cathode=7F and its anode stays 1. Digit 0 is never blanked, so value 0 displays a single "0". Overflow dashes are not blanked.
- Undefined: all NUM_DIGITS digits are always driven, including leading zeros.

Test Plan:
- Reset: hold reset_n=0 mid-scan and mid-SHIFT -> outputs immediately at reset values; after release the first terminal count shows anode=FE, cathode=40; busy stays 0.
- Conversion latency: BIN_WIDTH=27, load value=12345678 -> busy high exactly 28 cycles; display reads 1,2,3,4,5,6,7,8 across digits 7..0; overflow=0.
- Ignored load: load 99 then load 42 on the cycle after acceptance -> display shows 99; second load has no effect; busy length unchanged.
- Overflow: NUM_DIGITS=4, load 10000 -> overflow=1, all four digits cathode=3F; then load 9999 -> overflow=0, digits read 9999.
- Scan order/wrap: REFRESH_DIV=4, NUM_DIGITS=3 -> anode sequence 6,5,3,6 with a change every 4 clocks; old value stays on display throughout a conversion.
- Blanking (SEVEN_SEG_BLANK_EN defined): load 507, NUM_DIGITS=8 -> digits 7..3 have anode=1; digits 2..0 show 5,0,7; load 0 -> only digit 0 is lit, showing 40.
